// File: rtl/rob.sv
// Reorder buffer: in-order allocation and retirement, out-of-order completion,
// and branch-mispredict flush of every entry younger than the branch.
module rob #(
  parameter int unsigned ISSUE_WIDTH_MAX = 2,
  parameter int unsigned ROB_MAX_RETIRE  = 2,
  parameter int unsigned NUM_WB          = 2,
  parameter int unsigned ROB_SIZE        = 32,
  parameter int unsigned ROB_SIZE_CLOG   = 5,
  parameter int unsigned SRC_LEN         = 5,
  parameter int unsigned OPCODE_LEN      = 7
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [ISSUE_WIDTH_MAX-1:0]                   instr_val_id,
  input  logic [ISSUE_WIDTH_MAX-1:0][OPCODE_LEN-1:0]   opcode_id,
  input  logic [ISSUE_WIDTH_MAX-1:0][SRC_LEN-1:0]      rd_id,
  input  logic [NUM_WB-1:0]                            wb_val,
  input  logic [NUM_WB-1:0][ROB_SIZE_CLOG-1:0]         wb_robid,
  input  logic                                         mispredict,
  input  logic [ROB_SIZE_CLOG-1:0]                     mispredict_tag,
  output logic [ROB_SIZE_CLOG-1:0]                     rob_is_ptr,
  output logic [ROB_SIZE_CLOG-1:0]                     rob_is_ptr_p1,
  output logic                                         rob_full,
  output logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]       rd_ret,
  output logic [ROB_MAX_RETIRE-1:0]                    val_ret,
  output logic [ROB_MAX_RETIRE-1:0]                    branch_ret,
  output logic [ROB_MAX_RETIRE-1:0][ROB_SIZE_CLOG-1:0] robid_ret
);

  localparam int unsigned CW = ROB_SIZE_CLOG + 1;
  localparam logic [OPCODE_LEN-1:0] SB_TYPE = OPCODE_LEN'(7'b1100011);
  localparam logic [OPCODE_LEN-1:0] S_TYPE  = OPCODE_LEN'(7'b0100011);

  typedef logic [ROB_SIZE_CLOG-1:0] ptr_t;
  typedef logic [CW-1:0]            cnt_t;

  logic [ROB_SIZE-1:0] valid_q, valid_n;
  logic [ROB_SIZE-1:0] done_q, done_n;
  logic [ROB_SIZE-1:0] nowrite_q, nowrite_n;
  logic [SRC_LEN-1:0]  rd_q [ROB_SIZE];
  logic [SRC_LEN-1:0]  rd_n [ROB_SIZE];
  ptr_t                head_q, head_n, tail_q, tail_n;
  cnt_t                count_q, count_n;

  logic [ROB_MAX_RETIRE-1:0]                    ret_c;
  logic [ROB_MAX_RETIRE-1:0][ROB_SIZE_CLOG-1:0] ret_ptr_c;
  cnt_t                                         ret_cnt;
  logic                                         ret_chain;

  logic                                          alloc_en;
  logic [ISSUE_WIDTH_MAX-1:0]                    alloc_go;
  logic [ISSUE_WIDTH_MAX-1:0][ROB_SIZE_CLOG-1:0] alloc_ptr;
  cnt_t                                          alloc_cnt;

  logic flush_c;
  ptr_t tag_dist;

  logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0] rd_ret_n;
  logic [ROB_MAX_RETIRE-1:0]              branch_ret_n;

  // Issue-side status straight from registered pointers
  assign rob_is_ptr    = tail_q;
  assign rob_is_ptr_p1 = tail_q + ptr_t'(1);
  assign rob_full      = count_q > cnt_t'(ROB_SIZE - ISSUE_WIDTH_MAX);

  // Flush is honoured only when the branch entry is still live
  assign flush_c  = mispredict && valid_q[mispredict_tag];
  assign tag_dist = mispredict_tag - head_q;
  assign alloc_en = !rob_full && !mispredict;

  // In-order retire chain; entries younger than a flushing branch are squashed, not retired
  always_comb begin
    ret_c        = '0;
    ret_ptr_c    = '0;
    ret_cnt      = '0;
    ret_chain    = 1'b1;
    rd_ret_n     = '0;
    branch_ret_n = '0;
    for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
      ret_ptr_c[i] = head_q + ptr_t'(i);
      if (ret_chain && valid_q[ret_ptr_c[i]] && done_q[ret_ptr_c[i]] &&
          !(flush_c && (ptr_t'(i) > tag_dist))) begin
        ret_c[i]        = 1'b1;
        ret_cnt         = ret_cnt + cnt_t'(1);
        rd_ret_n[i]     = rd_q[ret_ptr_c[i]];
        branch_ret_n[i] = nowrite_q[ret_ptr_c[i]];
      end else begin
        ret_chain = 1'b0;
      end
    end
  end

  // Slots pack onto consecutive robids starting at tail, skipping invalid slots
  always_comb begin
    alloc_go  = '0;
    alloc_ptr = '0;
    alloc_cnt = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      alloc_ptr[i] = tail_q + ptr_t'(alloc_cnt);
      if (alloc_en && instr_val_id[i]) begin
        alloc_go[i] = 1'b1;
        alloc_cnt   = alloc_cnt + cnt_t'(1);
      end
    end
  end

  // Entry next-state: completion, retire, flush (overrides completion), then allocation
  always_comb begin
    valid_n   = valid_q;
    done_n    = done_q;
    nowrite_n = nowrite_q;
    rd_n      = rd_q;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_val[k] && valid_q[wb_robid[k]]) done_n[wb_robid[k]] = 1'b1;
    end
    for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
      if (ret_c[i]) valid_n[ret_ptr_c[i]] = 1'b0;
    end
    if (flush_c) begin
      for (int e = 0; e < ROB_SIZE; e++) begin
        if (ptr_t'(ptr_t'(e) - head_q) > tag_dist) begin
          valid_n[e] = 1'b0;
          done_n[e]  = 1'b0;
        end
      end
    end
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      if (alloc_go[i]) begin
        valid_n[alloc_ptr[i]]   = 1'b1;
        done_n[alloc_ptr[i]]    = 1'b0;
        nowrite_n[alloc_ptr[i]] = (opcode_id[i] == SB_TYPE) || (opcode_id[i] == S_TYPE);
        rd_n[alloc_ptr[i]]      = rd_id[i];
      end
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    head_n = head_q + ptr_t'(ret_cnt);
    if (flush_c) begin
      tail_n  = mispredict_tag + ptr_t'(1);
      count_n = cnt_t'(tag_dist) + cnt_t'(1) - ret_cnt;
    end else begin
      tail_n  = tail_q + ptr_t'(alloc_cnt);
      count_n = count_q + alloc_cnt - ret_cnt;
    end
  end

  // State and registered retire bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      done_q     <= '0;
      nowrite_q  <= '0;
      for (int e = 0; e < ROB_SIZE; e++) rd_q[e] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      val_ret    <= '0;
      rd_ret     <= '0;
      robid_ret  <= '0;
      branch_ret <= '0;
    end else begin
      valid_q    <= valid_n;
      done_q     <= done_n;
      nowrite_q  <= nowrite_n;
      for (int e = 0; e < ROB_SIZE; e++) rd_q[e] <= rd_n[e];
      head_q     <= head_n;
      tail_q     <= tail_n;
      count_q    <= count_n;
      val_ret    <= ret_c;
      rd_ret     <= rd_ret_n;
      robid_ret  <= ret_c[0] ? ret_ptr_c & {ROB_MAX_RETIRE{{ROB_SIZE_CLOG{1'b1}}}} : '0;
      branch_ret <= branch_ret_n;
      for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
        if (!ret_c[i]) robid_ret[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: scenario tasks plus an in-order retire scoreboard.
module tb_rob;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       instr_val_id;
  logic [1:0][6:0]  opcode_id;
  logic [1:0][4:0]  rd_id;
  logic [1:0]       wb_val;
  logic [1:0][4:0]  wb_robid;
  logic             mispredict;
  logic [4:0]       mispredict_tag;
  logic [4:0]       rob_is_ptr, rob_is_ptr_p1;
  logic             rob_full;
  logic [1:0][4:0]  rd_ret;
  logic [1:0]       val_ret, branch_ret;
  logic [1:0][4:0]  robid_ret;

  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_SB  = 7'b1100011;

  typedef struct packed {
    logic [4:0] robid;
    logic [4:0] rd;
    logic       br;
  } ret_t;

  ret_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_count;
  logic [4:0] exp_tail;

  rob dut (
    .clk(clk), .rst(rst),
    .instr_val_id(instr_val_id), .opcode_id(opcode_id), .rd_id(rd_id),
    .wb_val(wb_val), .wb_robid(wb_robid),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .rob_is_ptr(rob_is_ptr), .rob_is_ptr_p1(rob_is_ptr_p1), .rob_full(rob_full),
    .rd_ret(rd_ret), .val_ret(val_ret), .branch_ret(branch_ret), .robid_ret(robid_ret)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    instr_val_id   = '0;
    opcode_id      = '0;
    rd_id          = '0;
    wb_val         = '0;
    wb_robid       = '0;
    mispredict     = 1'b0;
    mispredict_tag = '0;
  endtask

  // Advance one edge and compare every retire slot against the scoreboard
  task automatic tick();
    ret_t e;
    @(posedge clk);
    #1;
    if (val_ret[1] && !val_ret[0]) begin
      checks++; errors++;
      $display("FAIL retire_order: val_ret=%b required slot 0 before slot 1", val_ret);
    end
    for (int i = 0; i < 2; i++) begin
      if (val_ret[i]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL retire_unexpected: slot %0d robid %0d with empty scoreboard", i, robid_ret[i]);
        end else begin
          e = sb.pop_front();
          exp_count--;
          if (robid_ret[i] !== e.robid || rd_ret[i] !== e.rd || branch_ret[i] !== e.br) begin
            errors++;
            $display("FAIL retire_slot%0d: got robid=%0d rd=%0d br=%b required robid=%0d rd=%0d br=%b",
                     i, robid_ret[i], rd_ret[i], branch_ret[i], e.robid, e.rd, e.br);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    #13;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    exp_count = 0;
    exp_tail  = '0;
  endtask

  // One allocation cycle; expected robids come from the bench's own tail/count model
  task automatic alloc(input logic [1:0] v, input logic [6:0] op0, input logic [4:0] r0,
                       input logic [6:0] op1, input logic [4:0] r1);
    logic full;
    int   k;
    full = (exp_count > 30);
    checks++;
    if (rob_full !== full) begin
      errors++; $display("FAIL alloc_full: rob_full=%b required %b", rob_full, full);
    end
    checks++;
    if (rob_is_ptr !== exp_tail) begin
      errors++; $display("FAIL alloc_ptr: rob_is_ptr=%0d required %0d", rob_is_ptr, exp_tail);
    end
    instr_val_id = v;
    opcode_id    = {op1, op0};
    rd_id        = {r1, r0};
    if (!full) begin
      k = 0;
      if (v[0]) begin sb.push_back('{robid: exp_tail + 5'(k), rd: r0, br: (op0 == OP_S || op0 == OP_SB)}); k++; end
      if (v[1]) begin sb.push_back('{robid: exp_tail + 5'(k), rd: r1, br: (op1 == OP_S || op1 == OP_SB)}); k++; end
      exp_tail  = exp_tail + 5'(k);
      exp_count = exp_count + k;
    end
    tick();
    set_idle();
  endtask

  task automatic complete(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1);
    wb_val   = v;
    wb_robid = {r1, r0};
    tick();
    set_idle();
  endtask

  task automatic drain(input int target);
    int n;
    n = 0;
    while (sb.size() > target && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() > target) begin
      errors++; $display("FAIL drain_timeout: %0d entries pending required %0d", sb.size(), target);
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b0;
    #3;
    checks++;
    if (rob_is_ptr !== 5'd0 || rob_is_ptr_p1 !== 5'd1 || rob_full !== 1'b0) begin
      errors++; $display("FAIL reset_ptrs: ptr=%0d p1=%0d full=%b required 0 1 0", rob_is_ptr, rob_is_ptr_p1, rob_full);
    end
    checks++;
    if (val_ret !== 2'b00 || rd_ret !== 10'd0 || robid_ret !== 10'd0 || branch_ret !== 2'b00) begin
      errors++; $display("FAIL reset_retire: val=%b rd=%h robid=%h br=%b required zeros", val_ret, rd_ret, robid_ret, branch_ret);
    end
    do_reset();
  endtask

  task automatic test_dual_alloc();
    do_reset();
    checks++;
    if (rob_is_ptr_p1 !== 5'd1) begin
      errors++; $display("FAIL dual_p1_before: got %0d required 1", rob_is_ptr_p1);
    end
    alloc(2'b11, OP_ALU, 5'd3, OP_ALU, 5'd5);
    checks++;
    if (rob_is_ptr !== 5'd2 || rob_is_ptr_p1 !== 5'd3) begin
      errors++; $display("FAIL dual_ptrs_after: ptr=%0d p1=%0d required 2 3", rob_is_ptr, rob_is_ptr_p1);
    end
    checks++;
    if (dut.count_q !== 6'd2) begin
      errors++; $display("FAIL dual_count: got %0d required 2", dut.count_q);
    end
  endtask

  task automatic test_retire_order();
    complete(2'b01, 5'd1, 5'd0);
    tick();
    tick();
    checks++;
    if (val_ret !== 2'b00) begin
      errors++; $display("FAIL early_retire: val_ret=%b required 00", val_ret);
    end
    complete(2'b01, 5'd0, 5'd0);
    checks++;
    if (val_ret !== 2'b00) begin
      errors++; $display("FAIL bypass_retire: val_ret=%b required 00", val_ret);
    end
    tick();
    checks++;
    if (val_ret !== 2'b11 || rd_ret !== {5'd5, 5'd3} || robid_ret !== {5'd1, 5'd0} || branch_ret !== 2'b00) begin
      errors++; $display("FAIL pair_retire: val=%b rd=%h robid=%h br=%b required 11 {5,3} {1,0} 00",
                         val_ret, rd_ret, robid_ret, branch_ret);
    end
    tick();
    checks++;
    if (val_ret !== 2'b00 || sb.size() != 0) begin
      errors++; $display("FAIL retire_hold: val_ret=%b pending=%0d required 00 0", val_ret, sb.size());
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 15; i++) alloc(2'b11, OP_ALU, 5'(i), OP_ALU, 5'(i + 1));
    checks++;
    if (rob_full !== 1'b0 || dut.count_q !== 6'd30) begin
      errors++; $display("FAIL full_at30: full=%b count=%0d required 0 30", rob_full, dut.count_q);
    end
    alloc(2'b01, OP_ALU, 5'd9, OP_ALU, 5'd0);
    checks++;
    if (rob_full !== 1'b1) begin
      errors++; $display("FAIL full_at31: full=%b required 1", rob_full);
    end
    alloc(2'b11, OP_ALU, 5'd7, OP_ALU, 5'd8);
    checks++;
    if (rob_is_ptr !== 5'd31 || dut.count_q !== 6'd31) begin
      errors++; $display("FAIL full_blocked: tail=%0d count=%0d required 31 31", rob_is_ptr, dut.count_q);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) alloc(2'b11, OP_ALU, 5'(i), OP_ALU, 5'(i + 16));
    for (int i = 0; i < 15; i++) complete(2'b11, 5'(2 * i), 5'(2 * i + 1));
    drain(0);
    checks++;
    if (rob_is_ptr !== 5'd30 || dut.head_q !== 5'd30 || dut.count_q !== 6'd0) begin
      errors++; $display("FAIL wrap_start: tail=%0d head=%0d count=%0d required 30 30 0", rob_is_ptr, dut.head_q, dut.count_q);
    end
    alloc(2'b11, OP_ALU, 5'd11, OP_SB, 5'd12);
    checks++;
    if (rob_is_ptr !== 5'd0 || rob_is_ptr_p1 !== 5'd1) begin
      errors++; $display("FAIL wrap_ptr: ptr=%0d p1=%0d required 0 1", rob_is_ptr, rob_is_ptr_p1);
    end
    alloc(2'b11, OP_ALU, 5'd13, OP_ALU, 5'd14);
    checks++;
    if (rob_is_ptr !== 5'd2) begin
      errors++; $display("FAIL wrap_ptr2: ptr=%0d required 2", rob_is_ptr);
    end
    complete(2'b11, 5'd30, 5'd31);
    complete(2'b11, 5'd0, 5'd1);
    drain(0);
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 3; i++) alloc(2'b11, OP_ALU, 5'(2 * i + 1), OP_ALU, 5'(2 * i + 2));
    mispredict     = 1'b1;
    mispredict_tag = 5'd2;
    wb_val         = 2'b01;
    wb_robid       = {5'd0, 5'd4};
    instr_val_id   = 2'b11;
    rd_id          = {5'd30, 5'd29};
    for (int i = 0; i < 3; i++) void'(sb.pop_back());
    exp_tail  = 5'd3;
    exp_count = 3;
    tick();
    set_idle();
    checks++;
    if (rob_is_ptr !== 5'd3 || dut.count_q !== 6'd3) begin
      errors++; $display("FAIL flush_ptrs: tail=%0d count=%0d required 3 3", rob_is_ptr, dut.count_q);
    end
    checks++;
    if (dut.valid_q[4] !== 1'b0 || dut.done_q[4] !== 1'b0) begin
      errors++; $display("FAIL flush_wb: valid4=%b done4=%b required 0 0", dut.valid_q[4], dut.done_q[4]);
    end
    mispredict     = 1'b1;
    mispredict_tag = 5'd20;
    instr_val_id   = 2'b11;
    tick();
    set_idle();
    checks++;
    if (rob_is_ptr !== 5'd3 || dut.count_q !== 6'd3) begin
      errors++; $display("FAIL invalid_tag: tail=%0d count=%0d required 3 3", rob_is_ptr, dut.count_q);
    end
    alloc(2'b11, OP_ALU, 5'd10, OP_ALU, 5'd11);
    complete(2'b11, 5'd0, 5'd1);
    complete(2'b11, 5'd2, 5'd3);
    drain(1);
    tick();
    tick();
    checks++;
    if (val_ret !== 2'b00 || dut.valid_q[4] !== 1'b1 || dut.done_q[4] !== 1'b0) begin
      errors++; $display("FAIL flush_younger: val_ret=%b valid4=%b done4=%b required 00 1 0",
                         val_ret, dut.valid_q[4], dut.done_q[4]);
    end
  endtask

  task automatic test_store_and_reset();
    do_reset();
    alloc(2'b01, OP_S, 5'd7, OP_ALU, 5'd0);
    alloc(2'b10, OP_ALU, 5'd0, OP_SB, 5'd8);
    alloc(2'b01, OP_ALU, 5'd9, OP_ALU, 5'd0);
    complete(2'b11, 5'd0, 5'd1);
    tick();
    checks++;
    if (val_ret !== 2'b11 || branch_ret !== 2'b11 || rd_ret !== {5'd8, 5'd7} || robid_ret !== {5'd1, 5'd0}) begin
      errors++; $display("FAIL store_retire: val=%b br=%b rd=%h robid=%h required 11 11 {8,7} {1,0}",
                         val_ret, branch_ret, rd_ret, robid_ret);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (rob_is_ptr !== 5'd0 || rob_is_ptr_p1 !== 5'd1 || rob_full !== 1'b0 ||
        val_ret !== 2'b00 || rd_ret !== 10'd0 || robid_ret !== 10'd0 || branch_ret !== 2'b00) begin
      errors++; $display("FAIL async_reset: ptr=%0d p1=%0d full=%b val=%b rd=%h robid=%h br=%b required reset values",
                         rob_is_ptr, rob_is_ptr_p1, rob_full, val_ret, rd_ret, robid_ret, branch_ret);
    end
    checks++;
    if (dut.valid_q !== 32'd0 || dut.count_q !== 6'd0) begin
      errors++; $display("FAIL reset_discard: valid=%h count=%0d required 0 0", dut.valid_q, dut.count_q);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_dual_alloc();
    test_retire_order();
    test_full();
    test_wrap();
    test_mispredict();
    test_store_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ISSUE_WIDTH_MAX, 2, allocation slots per cycle.
- ROB_MAX_RETIRE, 2, retire slots per cycle.
- NUM_WB, 2, completion ports.
- ROB_SIZE, 32, entries (power of two).
- ROB_SIZE_CLOG, 5, log2(ROB_SIZE).
- SRC_LEN, 5; OPCODE_LEN, 7.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- instr_val_id  in  [ISSUE_WIDTH_MAX]  valid decoded instruction per slot.
- opcode_id  in  [ISSUE_WIDTH_MAX][OPCODE_LEN]  opcode per slot.
- rd_id  in  [ISSUE_WIDTH_MAX][SRC_LEN]  destination register per slot.
- wb_val  in  [NUM_WB]  completion valid.
- wb_robid  in  [NUM_WB][ROB_SIZE_CLOG]  completing entry.
- mispredict  in  1  branch mispredict flush request.
- mispredict_tag  in  ROB_SIZE_CLOG  robid of the mispredicting branch.
- rob_is_ptr  out  ROB_SIZE_CLOG  tail; robid given to the first valid slot.
- rob_is_ptr_p1  out  ROB_SIZE_CLOG  (tail+1) mod ROB_SIZE.
- rob_full  out  1  fewer than ISSUE_WIDTH_MAX free entries.
- rd_ret  out  [ROB_MAX_RETIRE][SRC_LEN]  retiring rd.
- val_ret  out  [ROB_MAX_RETIRE]  retire slot valid.
- branch_ret  out  [ROB_MAX_RETIRE]  retiring entry writes no rd (SB_TYPE or S_TYPE).
- robid_ret  out  [ROB_MAX_RETIRE][ROB_SIZE_CLOG]  retiring robid.

Function
REQ-003 State: circular buffer of ROB_SIZE entries {valid, done, nowrite, rd}; head, tail of ROB_SIZE_CLOG bits, wrapping modulo ROB_SIZE; count of ROB_SIZE_CLOG+1 bits.
REQ-004 rob_is_ptr = tail and rob_is_ptr_p1 = tail+1 with wrap; rob_full = (count > ROB_SIZE-ISSUE_WIDTH_MAX); all three are combinational from registered state.
REQ-005 Allocation occurs only when ~rob_full and ~mispredict. Slot 0, if valid, takes tail. Slot 1, if valid, takes tail+1 when slot 0 is valid, otherwise tail. Each allocated entry is written {valid=1, done=0, rd, nowrite=(opcode==SB_TYPE or S_TYPE)}. Tail advances by the number of allocations.
REQ-006 When rob_full=1, instructions are not allocated; tail and entries are unchanged.
REQ-007 Completion: wb_val[k] sets done for entry wb_robid[k] only if that entry is valid; otherwise the write is ignored. Multiple ports may target distinct entries in the same cycle.
REQ-008 Retire is in order, evaluated on registered state.
- Slot 0 retires head if head is valid and done.
- Slot 1 retires head+1 only if slot 0 retires and head+1 is valid and done.
- Retired entries have valid cleared; head advances by the number retired.
REQ-009 Retire bus is registered: val_ret, rd_ret, robid_ret and branch_ret update at the retiring edge and hold for one cycle. val_ret=0 in cycles with no retire.
REQ-010 Latency: a completion sampled at edge N makes the entry eligible at edge N+1, so val_ret is visible after edge N+1. A completion is not bypassed into the same-edge retire decision.
REQ-011 count_next = count + allocated - retired.
REQ-012 Mispredict, when mispredict=1 and entry mispredict_tag is valid:
- tail <= mispredict_tag+1 (with wrap).
- Entries from tag+1 through old tail-1 are invalidated.
- Allocation is suppressed.
- Retire proceeds normally.
- count_next = ((tag-head) mod ROB_SIZE) + 1 - retired.
A mispredict with an invalid tag entry is ignored, and allocation is still suppressed.
REQ-013 A completion targeting an entry flushed in the same cycle is ignored.
REQ-014 All pointer arithmetic wraps modulo ROB_SIZE; count never exceeds ROB_SIZE.

Reset
REQ-015 rst low asynchronously forces the following, regardless of clk:
- head=0, tail=0, count=0.
- All entries valid=0, done=0.
- val_ret=0, rd_ret=0, robid_ret=0, branch_ret=0.
Outputs therefore read rob_is_ptr=0, rob_is_ptr_p1=1, rob_full=0.
REQ-016 After rst rises, the first posedge may allocate. Reset asserted mid-operation discards all in-flight entries.

Verification
REQ-017 Scenario: reset, then instr_val_id=2'b11, rd_id={5,3}. Required: rob_is_ptr 0 then 2; rob_is_ptr_p1 1 then 3; count 2.
REQ-018 Scenario: wb robid 1, then a later cycle wb robid 0. Required: no retire after the first completion; one edge after the robid 0 completion, val_ret=2'b11, rd_ret={5,3}, robid_ret={1,0}, branch_ret=0.
REQ-019 Scenario: 15 dual allocations (count 30), then a single allocation. Required: rob_full=0 at count 30 and 1 at count 31; a further instr_val_id=2'b11 leaves tail=31.
REQ-020 Scenario: head=tail=30, count=0; allocate 2, then allocate 2 more. Required: robids 30,31, then 0,1; rob_is_ptr wraps to 0.
REQ-021 Scenario: allocate robids 0..5, then mispredict tag=2 with wb robid 4 in the same cycle. Required: tail=3, count=3, robid 4 done ignored; the next allocation gets robid 3.
REQ-022 Scenario: an S_TYPE entry at head completes. Required: val_ret[0]=1 and branch_ret[0]=1. Then assert rst low mid-stream; required: all outputs return to reset values without a clock edge.
